rca_response_checker: RTL and testbench
=======================================

# rca_response_checker

Self-checking response monitor for the 8-bit ripple-carry adder. It consumes the same operand stream the stimulus side drives into `RcaAdder_A_1`, along with the adder's `io_sum`/`io_cout`. It computes the golden result internally, aligns it to the adder output through a configurable latency pipe, and reports pass/fail counts plus the first failing vector. It sits beside the adder in the test harness, on the result end of the stimulus → adder → result path.

## Interface
- `WIDTH`, 8, operand width; `io_sum` is `WIDTH` bits
- `LAT`, 0, adder latency in cycles from operand presentation to a valid `io_sum`/`io_cout`; legal range 0–4
- `clock` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `io_start` in 1: pulse; starts a run from IDLE, DONE or HALT
- `io_num_vectors` in 16: vectors per run; sampled on `io_start`
- `io_stop_on_fail` in 1: sampled on `io_start`; when 1, the first mismatch ends the run
- `io_in_valid` in 1: operands on `io_a`/`io_b`/`io_cin` are valid this cycle
- `io_a`, `io_b` in `WIDTH`: operands as driven to the adder
- `io_cin` in 1: carry-in as driven to the adder
- `io_sum` in `WIDTH`: adder sum
- `io_cout` in 1: adder carry-out
- `io_busy` out 1: state is RUN
- `io_done` out 1: state is DONE
- `io_halted` out 1: state is HALT
- `io_mismatch` out 1: one-cycle pulse per failing check
- `io_pass_count` out 16: passing checks in the current run
- `io_fail_count` out 16: failing checks in the current run
- `io_first_fail_valid` out 1: first-fail capture registers hold data
- `io_first_fail_a`, `io_first_fail_b` out `WIDTH`: operands of the first failing check
- `io_first_fail_cin` out 1: carry-in of the first failing check
- `io_first_fail_got` out `WIDTH`+1: `{io_cout, io_sum}` observed at the first failing check

## Operation
- States: IDLE, RUN, DONE, HALT. Reset → IDLE.
- IDLE/DONE/HALT + `io_start` → RUN. Entering RUN does all of the following:
  - latches `io_num_vectors` and `io_stop_on_fail`
  - clears both counters, the issued count and the first-fail capture
  - flushes the delay pipe
- Issue:
  - In RUN, a cycle with `io_in_valid=1` and issued count < `io_num_vectors` issues one vector.
  - An issued vector pushes {valid, a, b, cin, expected} into stage 0 of the pipe.
  - `expected = a + b + cin`, computed at `WIDTH`+1 bits with no truncation.
  - Valid inputs beyond `io_num_vectors`, or arriving outside RUN, are ignored.
- Check:
  - The entry that is `LAT` cycles old is compared with `{io_cout, io_sum}`.
  - With `LAT=0`, the comparison happens in the issue cycle itself.
  - Equal → `io_pass_count` increments. Different → `io_fail_count` increments and `io_mismatch` pulses.
  - If the mismatch is the run's first, the capture registers load and `io_first_fail_valid` sets.
  - Both counters saturate at 0xFFFF.
- Run end:
  - RUN → DONE when checked count (pass + fail, unsaturated internal 17-bit sum) reaches the latched `io_num_vectors`.
  - RUN → HALT on a mismatch when the latched `io_stop_on_fail` is 1. HALT has priority over DONE in the same cycle.
  - With `io_num_vectors=0`, RUN → DONE on the cycle after start.
- Leaving RUN discards in-flight pipe entries. Counters and the capture hold until the next `io_start`.
- `io_start` during RUN is ignored.

## Timing
- Reset: state IDLE; every output is 0; pipe valids are 0.
- All status outputs are registered. A check at edge N is visible after edge N, i.e. outputs update in the cycle after the comparison.
- `io_busy` rises in the cycle after the `io_start` edge.
- `io_done`/`io_halted` rise in the cycle after the final or failing check.
- `reset` mid-run: the next edge returns the block to the reset values, regardless of `io_start`.
- Simultaneous issue and check, e.g. a back-to-back stream with `LAT>0`, is fully supported at one vector per cycle.

## Test plan
- All-pass run:
  - Setup: `LAT=0`, `io_num_vectors=4`, golden adder.
  - Vectors (a, b, cin): (3,4,0), (255,1,0), (255,255,1), (0,0,0).
  - Required: `io_pass_count=4`, `io_fail_count=0`, `io_done=1`.
  - Expected values 7, 256, 511, 0 must pass; carry-out is included in the compare.
- Injected fault, continue mode:
  - Setup: `io_stop_on_fail=0`; on vector 2 (10,20,1), force `io_sum=30`.
  - Required: exactly one `io_mismatch` pulse; `io_first_fail_a=10`, `io_first_fail_b=20`, `io_first_fail_got=30`.
  - Required at end: `io_fail_count=1`, `io_pass_count=3`, `io_done=1`.
- Stop on fail:
  - Setup: `io_stop_on_fail=1`, same fault.
  - Required: `io_halted=1` in the cycle after the failing check.
  - Required: later valid vectors are ignored; counters are frozen at pass 1, fail 1.
- Latency alignment:
  - Setup: `LAT=2`, golden adder with a 2-cycle registered output, 8 back-to-back vectors.
  - Required: all 8 pass.
  - Same vectors with the DUT at 1-cycle latency: failures reported.
- Limits:
  - `io_num_vectors=0` → DONE one cycle after start, counters 0.
  - 70000 passing vectors with `io_num_vectors` = 0xFFFF → run ends at 65535 checks with `io_pass_count=0xFFFF`.
  - `io_start` during RUN → no effect.
- Reset mid-run:
  - Stimulus: `reset` asserted while `io_pass_count=5`.
  - Required: the next cycle shows all outputs 0 and state IDLE.
  - Required: a subsequent `io_start` runs normally.

Source files
------------

// File: rtl/rca_response_checker.sv
// Response checker for a ripple-carry adder.
// Recomputes a + b + cin for each issued operand set and delays it by LAT
// cycles, so it lines up with the adder's {io_cout, io_sum}. It counts passing
// and failing checks and records the first failing vector of the run.
module rca_response_checker #(
  parameter int WIDTH = 8,
  parameter int LAT   = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_start,
  input  logic [15:0]      io_num_vectors,
  input  logic             io_stop_on_fail,
  input  logic             io_in_valid,
  input  logic [WIDTH-1:0] io_a,
  input  logic [WIDTH-1:0] io_b,
  input  logic             io_cin,
  input  logic [WIDTH-1:0] io_sum,
  input  logic             io_cout,
  output logic             io_busy,
  output logic             io_done,
  output logic             io_halted,
  output logic             io_mismatch,
  output logic [15:0]      io_pass_count,
  output logic [15:0]      io_fail_count,
  output logic             io_first_fail_valid,
  output logic [WIDTH-1:0] io_first_fail_a,
  output logic [WIDTH-1:0] io_first_fail_b,
  output logic             io_first_fail_cin,
  output logic [WIDTH:0]   io_first_fail_got
);

  typedef enum logic [1:0] {IDLE, RUN, DONE, HALT} state_t;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH:0]   exp;
  } entry_t;

  state_t           state_reg, state_next;
  logic [15:0]      num_reg;
  logic             stop_reg;
  logic [15:0]      issued_reg;
  logic [15:0]      pass_reg, fail_reg;
  logic             mismatch_reg;
  logic             ff_valid_reg;
  logic [WIDTH-1:0] ff_a_reg, ff_b_reg;
  logic             ff_cin_reg;
  logic [WIDTH:0]   ff_got_reg;

  logic             is_run, start_run, issue;
  logic             check_v, check_fail, check_pass;
  logic [WIDTH:0]   got;
  logic [16:0]      checked_now;
  entry_t           issue_entry, chk_entry;

  // Issue decision and the golden entry (full WIDTH+1 bit result, no truncation)
  always_comb begin
    is_run            = (state_reg == RUN);
    start_run         = !is_run && io_start;
    issue             = is_run && io_in_valid && (issued_reg < num_reg);
    issue_entry.valid = issue;
    issue_entry.a     = io_a;
    issue_entry.b     = io_b;
    issue_entry.cin   = io_cin;
    issue_entry.exp   = {1'b0, io_a} + {1'b0, io_b} + {{WIDTH{1'b0}}, io_cin};
  end

  // Delay pipe: stage gi holds the entry issued gi+1 cycles ago; flushed
  // whenever the block is not staying in RUN so stale entries never get checked.
  generate
    if (LAT == 0) begin : g_nopipe
      assign chk_entry = issue_entry;
    end else begin : g_pipe
      logic pipe_run;
      assign pipe_run = (state_reg == RUN) && (state_next == RUN);
      for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
        entry_t stage_reg;
        // Shift one stage per cycle, clearing on reset or flush
        always_ff @(posedge clock) begin
          if (reset || !pipe_run) begin
            stage_reg <= '0;
          end else if (gi == 0) begin
            stage_reg <= issue_entry;
          end else begin
            stage_reg <= g_stage[(gi == 0) ? 0 : gi - 1].stage_reg;
          end
        end
      end
      assign chk_entry = g_stage[LAT-1].stage_reg;
    end
  endgenerate

  // Compare the aligned entry with the adder output; checked_now is unsaturated
  always_comb begin
    got         = {io_cout, io_sum};
    check_v     = is_run && chk_entry.valid;
    check_fail  = check_v && (got != chk_entry.exp);
    check_pass  = check_v && !check_fail;
    checked_now = {1'b0, pass_reg} + {1'b0, fail_reg} + {16'd0, check_v};
  end

  // Next-state logic; a halting mismatch wins over reaching the vector count
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE, HALT: if (io_start) state_next = RUN;
      RUN: begin
        if (check_fail && stop_reg) begin
          state_next = HALT;
        end else if (checked_now >= {1'b0, num_reg}) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Run configuration, counters and first-fail capture
  always_ff @(posedge clock) begin
    if (reset) begin
      num_reg      <= '0;
      stop_reg     <= 1'b0;
      issued_reg   <= '0;
      pass_reg     <= '0;
      fail_reg     <= '0;
      mismatch_reg <= 1'b0;
      ff_valid_reg <= 1'b0;
      ff_a_reg     <= '0;
      ff_b_reg     <= '0;
      ff_cin_reg   <= 1'b0;
      ff_got_reg   <= '0;
    end else begin
      mismatch_reg <= 1'b0;
      if (start_run) begin
        num_reg      <= io_num_vectors;
        stop_reg     <= io_stop_on_fail;
        issued_reg   <= '0;
        pass_reg     <= '0;
        fail_reg     <= '0;
        ff_valid_reg <= 1'b0;
        ff_a_reg     <= '0;
        ff_b_reg     <= '0;
        ff_cin_reg   <= 1'b0;
        ff_got_reg   <= '0;
      end else if (is_run) begin
        if (issue) issued_reg <= issued_reg + 16'd1;
        if (check_pass && pass_reg != 16'hFFFF) pass_reg <= pass_reg + 16'd1;
        if (check_fail && fail_reg != 16'hFFFF) fail_reg <= fail_reg + 16'd1;
        mismatch_reg <= check_fail;
        if (check_fail && !ff_valid_reg) begin
          ff_valid_reg <= 1'b1;
          ff_a_reg     <= chk_entry.a;
          ff_b_reg     <= chk_entry.b;
          ff_cin_reg   <= chk_entry.cin;
          ff_got_reg   <= got;
        end
      end
    end
  end

  assign io_busy             = (state_reg == RUN);
  assign io_done             = (state_reg == DONE);
  assign io_halted           = (state_reg == HALT);
  assign io_mismatch         = mismatch_reg;
  assign io_pass_count       = pass_reg;
  assign io_fail_count       = fail_reg;
  assign io_first_fail_valid = ff_valid_reg;
  assign io_first_fail_a     = ff_a_reg;
  assign io_first_fail_b     = ff_b_reg;
  assign io_first_fail_cin   = ff_cin_reg;
  assign io_first_fail_got   = ff_got_reg;

endmodule

// File: tb/tb_rca_response_checker.sv
// Bench for rca_response_checker: one checker with LAT=0 and one with LAT=2,
// each fed by a behavioural adder with optional injected result corruption.
module tb_rca_response_checker;

  logic       clock = 1'b0;
  logic       reset;
  logic       start0, start2;
  logic [15:0] num;
  logic       stop;
  logic       in_valid;
  logic [7:0] a, b;
  logic       cin;
  logic [8:0] fmask;
  logic       one_cycle;
  logic       sel;

  always #5 clock = ~clock;

  // Adder models: combinational for LAT=0, registered 2 (or 1) cycles for LAT=2
  logic [8:0] res0, d1, d2, res2;
  assign res0 = ({1'b0, a} + {1'b0, b} + {8'd0, cin}) ^ fmask;
  always @(posedge clock) begin
    d1 <= res0;
    d2 <= d1;
  end
  assign res2 = one_cycle ? d1 : d2;

  logic        busy0, done0, halt0, mm0, ffv0, ffc0;
  logic [15:0] pass0, fail0;
  logic [7:0]  ffa0, ffb0;
  logic [8:0]  ffg0;
  logic        busy2, done2, halt2, mm2, ffv2, ffc2;
  logic [15:0] pass2, fail2;
  logic [7:0]  ffa2, ffb2;
  logic [8:0]  ffg2;

  rca_response_checker #(.WIDTH(8), .LAT(0)) dut0 (
    .clock(clock), .reset(reset), .io_start(start0), .io_num_vectors(num),
    .io_stop_on_fail(stop), .io_in_valid(in_valid), .io_a(a), .io_b(b),
    .io_cin(cin), .io_sum(res0[7:0]), .io_cout(res0[8]),
    .io_busy(busy0), .io_done(done0), .io_halted(halt0), .io_mismatch(mm0),
    .io_pass_count(pass0), .io_fail_count(fail0), .io_first_fail_valid(ffv0),
    .io_first_fail_a(ffa0), .io_first_fail_b(ffb0), .io_first_fail_cin(ffc0),
    .io_first_fail_got(ffg0));

  rca_response_checker #(.WIDTH(8), .LAT(2)) dut2 (
    .clock(clock), .reset(reset), .io_start(start2), .io_num_vectors(num),
    .io_stop_on_fail(stop), .io_in_valid(in_valid), .io_a(a), .io_b(b),
    .io_cin(cin), .io_sum(res2[7:0]), .io_cout(res2[8]),
    .io_busy(busy2), .io_done(done2), .io_halted(halt2), .io_mismatch(mm2),
    .io_pass_count(pass2), .io_fail_count(fail2), .io_first_fail_valid(ffv2),
    .io_first_fail_a(ffa2), .io_first_fail_b(ffb2), .io_first_fail_cin(ffc2),
    .io_first_fail_got(ffg2));

  // Outputs of whichever checker the current run targets
  logic        s_busy, s_done, s_halt, s_mm, s_ffv, s_ffc;
  logic [15:0] s_pass, s_fail;
  logic [7:0]  s_ffa, s_ffb;
  logic [8:0]  s_ffg;
  assign s_busy = sel ? busy2 : busy0;
  assign s_done = sel ? done2 : done0;
  assign s_halt = sel ? halt2 : halt0;
  assign s_mm   = sel ? mm2   : mm0;
  assign s_ffv  = sel ? ffv2  : ffv0;
  assign s_ffc  = sel ? ffc2  : ffc0;
  assign s_pass = sel ? pass2 : pass0;
  assign s_fail = sel ? fail2 : fail0;
  assign s_ffa  = sel ? ffa2  : ffa0;
  assign s_ffb  = sel ? ffb2  : ffb0;
  assign s_ffg  = sel ? ffg2  : ffg0;

  int n_checks = 0;
  int n_errors = 0;
  int mm_count = 0;

  logic [7:0] va [0:63];
  logic [7:0] vb [0:63];
  logic       vc [0:63];
  logic [8:0] vm [0:63];

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_checks++;
    if (got_v !== exp_v) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got_v, exp_v);
    end
  endtask

  // Advance to the next falling edge, tallying mismatch pulses on the way
  task automatic step();
    @(negedge clock);
    if (s_mm) mm_count++;
  endtask

  task automatic set_vec(input int i, input int av, input int bv, input int cv, input int mv);
    va[i] = 8'(av); vb[i] = 8'(bv); vc[i] = 1'(cv); vm[i] = 9'(mv);
  endtask

  task automatic pulse_start(input logic s, input int n, input logic stp);
    sel = s;
    num = 16'(n);
    stop = stp;
    if (s) start2 = 1'b1; else start0 = 1'b1;
    step();
    start0 = 1'b0;
    start2 = 1'b0;
  endtask

  // One run: the reference outcome is computed from the vector list alone
  task automatic run(input logic s, input int n, input int total, input logic stp,
                     input int gap_max, input string tag);
    int ep, ef, halt_idx, g;
    logic eh, effv, ec;
    logic [7:0] ea, eb;
    logic [8:0] eg, obs;
    ep = 0; ef = 0; halt_idx = -1; eh = 0; effv = 0; ea = 0; eb = 0; ec = 0; eg = 0;
    for (int i = 0; i < total && i < n && !eh; i++) begin
      g = int'(va[i]) + int'(vb[i]) + int'(vc[i]);
      obs = 9'(g) ^ vm[i];
      if (obs != 9'(g)) begin
        ef++;
        if (!effv) begin
          effv = 1; ea = va[i]; eb = vb[i]; ec = vc[i]; eg = obs;
        end
        if (stp) begin
          eh = 1; halt_idx = i;
        end
      end else begin
        ep++;
      end
    end
    mm_count = 0;
    pulse_start(s, n, stp);
    for (int i = 0; i < total; i++) begin
      repeat ($urandom_range(gap_max, 0)) step();
      in_valid = 1'b1; a = va[i]; b = vb[i]; cin = vc[i]; fmask = vm[i];
      step();
      in_valid = 1'b0; fmask = 9'd0;
      if (!s && i == halt_idx) check({tag, "_halt_next"}, 32'(s_halt), 32'd1);
    end
    for (int k = 0; k < 20 && !(s_done || s_halt); k++) step();
    check({tag, "_done"}, 32'(s_done), 32'(!eh));
    check({tag, "_halted"}, 32'(s_halt), 32'(eh));
    check({tag, "_pass"}, 32'(s_pass), 32'(ep));
    check({tag, "_fail"}, 32'(s_fail), 32'(ef));
    check({tag, "_pulses"}, 32'(mm_count), 32'(ef));
    check({tag, "_ffv"}, 32'(s_ffv), 32'(effv));
    if (effv) begin
      check({tag, "_ff_a"}, 32'(s_ffa), 32'(ea));
      check({tag, "_ff_b"}, 32'(s_ffb), 32'(eb));
      check({tag, "_ff_cin"}, 32'(s_ffc), 32'(ec));
      check({tag, "_ff_got"}, 32'(s_ffg), 32'(eg));
    end
    $display("run %s lat=%0d n=%0d total=%0d stop=%0d pass=%0d fail=%0d", tag,
             s ? 2 : 0, n, total, stp, s_pass, s_fail);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(s_busy), 32'd0);
    check({tag, "_done"}, 32'(s_done), 32'd0);
    check({tag, "_halted"}, 32'(s_halt), 32'd0);
    check({tag, "_mm"}, 32'(s_mm), 32'd0);
    check({tag, "_pass"}, 32'(s_pass), 32'd0);
    check({tag, "_fail"}, 32'(s_fail), 32'd0);
    check({tag, "_ffv"}, 32'(s_ffv), 32'd0);
    check({tag, "_ff_got"}, 32'({s_ffa, s_ffb, s_ffc, s_ffg}), 32'd0);
  endtask

  task automatic load_directed(input int fault_mask);
    set_vec(0, 3, 4, 0, 0);
    set_vec(1, 10, 20, 1, fault_mask);
    set_vec(2, 255, 1, 0, 0);
    set_vec(3, 255, 255, 1, 0);
  endtask

  initial begin
    reset = 1'b1; start0 = 0; start2 = 0; num = 0; stop = 0; in_valid = 0;
    a = 0; b = 0; cin = 0; fmask = 0; one_cycle = 0; sel = 0;
    repeat (3) step();
    sel = 0; check_idle("reset0");
    sel = 1; check_idle("reset2");
    reset = 1'b0;
    step();

    // Golden adder, LAT=0: sums 7, 256, 511, 0
    set_vec(0, 3, 4, 0, 0); set_vec(1, 255, 1, 0, 0);
    set_vec(2, 255, 255, 1, 0); set_vec(3, 0, 0, 0, 0);
    run(1'b0, 4, 4, 1'b0, 0, "all_pass");

    // Vector 2 (10,20,1) reported as 30 instead of 31
    load_directed(1);
    run(1'b0, 4, 4, 1'b0, 0, "fault_cont");
    run(1'b0, 4, 4, 1'b1, 0, "fault_stop");

    // LAT=2 back-to-back
    for (int i = 0; i < 8; i++) set_vec(i, i * 37, i * 11 + 5, i & 1, 0);
    run(1'b1, 8, 8, 1'b0, 0, "lat2");

    // Adder answers one cycle early: misaligned results must fail
    one_cycle = 1'b1;
    pulse_start(1'b1, 8, 1'b0);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; a = va[i]; b = vb[i]; cin = vc[i];
      step();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 20 && !s_done; k++) step();
    check("lat_short_fails", 32'(s_fail != 0), 32'd1);
    check("lat_short_done", 32'(s_done), 32'd1);
    $display("run lat_short pass=%0d fail=%0d", s_pass, s_fail);
    one_cycle = 1'b0;

    // Zero-length run ends the cycle after it starts
    pulse_start(1'b0, 0, 1'b0);
    check("zero_busy", 32'(s_busy), 32'd1);
    step();
    check("zero_done", 32'(s_done), 32'd1);
    check("zero_counts", 32'({s_pass, s_fail}), 32'd0);
    $display("run zero done=%0d", s_done);

    // Start pulse while running must neither restart nor re-latch the count
    pulse_start(1'b0, 3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; a = 8'(i + 1); b = 8'(i * 2); cin = 1'b0;
      if (i == 1) begin start0 = 1'b1; num = 16'd10; end
      step();
      start0 = 1'b0;
    end
    in_valid = 1'b0;
    check("restart_pass", 32'(s_pass), 32'd3);
    check("restart_done", 32'(s_done), 32'd1);
    $display("run restart pass=%0d done=%0d", s_pass, s_done);

    // Reset in the middle of a run
    pulse_start(1'b0, 20, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      step();
    end
    in_valid = 1'b0;
    check("midrst_before", 32'(s_pass), 32'd5);
    reset = 1'b1; start0 = 1'b1;
    step();
    check_idle("midrst");
    reset = 1'b0; start0 = 1'b0;
    step();
    load_directed(0);
    run(1'b0, 4, 4, 1'b0, 0, "after_rst");

    // Randomized runs on both latencies
    for (int r = 0; r < 30; r++) begin
      int n, total;
      n = $urandom_range(12, 1);
      total = n + $urandom_range(3, 0);
      for (int i = 0; i < total; i++)
        set_vec(i, $urandom_range(255, 0), $urandom_range(255, 0), $urandom_range(1, 0),
                ($urandom_range(4, 0) == 0) ? $urandom_range(511, 1) : 0);
      run(1'(r & 1), n, total, 1'($urandom_range(1, 0)), $urandom_range(2, 0), "rand");
    end

    // Maximum-length run: stops at 65535 checks
    pulse_start(1'b0, 16'hFFFF, 1'b0);
    for (int i = 0; i < 65600; i++) begin
      in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      step();
    end
    in_valid = 1'b0;
    check("max_pass", 32'(s_pass), 32'hFFFF);
    check("max_fail", 32'(s_fail), 32'd0);
    check("max_done", 32'(s_done), 32'd1);
    $display("run max pass=%0d done=%0d", s_pass, s_done);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
